// File: rtl/ps2_field_entry.sv
// PS/2 numeric-entry controller: function keys select one of NUM_FIELDS fields, decimal
// digits are edited in a BCD buffer, converted serially to binary, clamped and committed.
module ps2_field_entry #(
    parameter int NUM_FIELDS = 3,
    parameter int DIGITS     = 3,
    parameter int VAL_W      = 10,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 300,
    parameter int PULSE_DIV  = 12_500_000
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [7:0]                  data,
    input  logic                        data_en,
    output logic [NUM_FIELDS*VAL_W-1:0] values,
    output logic [NUM_FIELDS-1:0]       commit,
    output logic                        editing,
    output logic [1:0]                  sel,
    output logic [DIGITS*4-1:0]         digits_bcd,
    output logic [NUM_FIELDS-1:0]       led
);
    localparam int BUF_W = DIGITS * 4;
    localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;

    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_BKSP  = 8'h66;
    localparam logic [7:0] KEY_BRK   = 8'hF0;
    localparam logic [7:0] KEY_EXT   = 8'hE0;

    typedef enum logic [1:0] {IDLE, EDIT, CONVERT, COMMIT} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         sel_reg, sel_next;
    logic [BUF_W-1:0]   buf_reg, buf_next;
    logic [2:0]         cnt_reg, cnt_next;
    logic [BUF_W-1:0]   acc_reg, acc_next;
    logic [1:0]         idx_reg, idx_next;
    logic               brk_reg, brk_next;
    logic               ext_reg, ext_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic               blink_reg, blink_next;
    logic [VAL_W-1:0]   values_reg [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] led_reg;

    // Returns {hit, value} for a set-2 digit make code.
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        case (code)
            8'h45:   return 5'h10;
            8'h16:   return 5'h11;
            8'h1E:   return 5'h12;
            8'h26:   return 5'h13;
            8'h25:   return 5'h14;
            8'h2E:   return 5'h15;
            8'h36:   return 5'h16;
            8'h3D:   return 5'h17;
            8'h3E:   return 5'h18;
            8'h46:   return 5'h19;
            default: return 5'h00;
        endcase
    endfunction

    // Returns {hit, field index} for F1..F4.
    function automatic logic [2:0] fkey_of(input logic [7:0] code);
        case (code)
            8'h05:   return 3'b100;
            8'h06:   return 3'b101;
            8'h04:   return 3'b110;
            8'h0C:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Prefix filtering; bytes outside IDLE/EDIT never reach the key decoder or the flags.
    logic       key_valid;
    logic [7:0] key_code;
    always_comb begin
        brk_next  = brk_reg;
        ext_next  = ext_reg;
        key_valid = 1'b0;
        key_code  = data;
        if (data_en && (state_reg == IDLE || state_reg == EDIT)) begin
            if (brk_reg) begin
                brk_next = 1'b0;
                ext_next = 1'b0;
            end else if (data == KEY_BRK) begin
                brk_next = 1'b1;
            end else if (data == KEY_EXT) begin
                ext_next = 1'b1;
            end else if (ext_reg) begin
                ext_next  = 1'b0;
                key_valid = (data == KEY_ENTER);
            end else begin
                key_valid = 1'b1;
            end
        end
    end

    logic [4:0] dig;
    logic [2:0] fk;
    logic       fkey_ok;
    logic       digit_ok;
    assign dig      = digit_of(key_code);
    assign fk       = fkey_of(key_code);
    assign fkey_ok  = key_valid && fk[2] && (int'(fk[1:0]) < NUM_FIELDS);
    assign digit_ok = key_valid && dig[4];

    // Serial conversion step, MSD first.
    logic [3:0]       cur_digit;
    logic [BUF_W-1:0] acc_step;
    int               acc_int;
    logic [VAL_W-1:0] clamped;
    logic             commit_we;
    assign cur_digit = 4'(buf_reg >> {idx_reg, 2'b00});
    assign acc_step  = BUF_W'(acc_reg * BUF_W'(10)) + BUF_W'(cur_digit);
    assign acc_int   = int'(acc_step);
    assign commit_we = (state_reg == CONVERT) && (idx_reg == 2'd0);

    always_comb begin
        if (acc_int > MAX_VAL)
            clamped = VAL_W'(MAX_VAL);
        else if (acc_int < MIN_VAL)
            clamped = VAL_W'(MIN_VAL);
        else
            clamped = VAL_W'(acc_step);
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (fkey_ok) begin
                    state_next = EDIT;
                    sel_next   = fk[1:0];
                    buf_next   = '0;
                    cnt_next   = '0;
                end
            end
            EDIT: begin
                if (fkey_ok) begin
                    sel_next = fk[1:0];
                    buf_next = '0;
                    cnt_next = '0;
                end else if (digit_ok) begin
                    if (int'(cnt_reg) < DIGITS) begin
                        buf_next = BUF_W'({buf_reg, dig[3:0]});
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else if (key_valid && key_code == KEY_BKSP) begin
                    if (cnt_reg != 3'd0) begin
                        buf_next = buf_reg >> 4;
                        cnt_next = cnt_reg - 3'd1;
                    end
                end else if (key_valid && key_code == KEY_ESC) begin
                    state_next = IDLE;
                end else if (key_valid && key_code == KEY_ENTER) begin
                    if (cnt_reg == 3'd0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = CONVERT;
                        acc_next   = '0;
                        idx_next   = 2'(DIGITS - 1);
                    end
                end
            end
            CONVERT: begin
                acc_next = acc_step;
                if (idx_reg == 2'd0)
                    state_next = COMMIT;
                else
                    idx_next = idx_reg - 2'd1;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_next   = div_reg + 1'b1;
        blink_next = blink_reg;
        if (div_reg == DIV_W'(PULSE_DIV - 1)) begin
            div_next   = '0;
            blink_next = ~blink_reg;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            buf_reg   <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            brk_reg   <= 1'b0;
            ext_reg   <= 1'b0;
            div_reg   <= '0;
            blink_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            idx_reg   <= idx_next;
            brk_reg   <= brk_next;
            ext_reg   <= ext_next;
            div_reg   <= div_next;
            blink_reg <= blink_next;
        end
    end

    // Per-field value register, status LED and commit pulse.
    // The value is written on the edge entering COMMIT so it lines up with the pulse.
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
            always_ff @(posedge CLOCK_50 or posedge reset) begin
                if (reset) begin
                    values_reg[gi] <= VAL_W'(MIN_VAL);
                    led_reg[gi]    <= 1'b0;
                end else begin
                    if (commit_we && sel_reg == 2'(gi))
                        values_reg[gi] <= clamped;
                    if (state_next != IDLE && sel_next == 2'(gi))
                        led_reg[gi] <= blink_next;
                    else
                        led_reg[gi] <= 1'b1;
                end
            end
            assign values[gi*VAL_W +: VAL_W] = values_reg[gi];
            assign commit[gi] = (state_reg == COMMIT) && (sel_reg == 2'(gi));
        end
    endgenerate

    assign editing    = (state_reg != IDLE);
    assign sel        = sel_reg;
    assign digits_bcd = buf_reg;
    assign led        = led_reg;

endmodule

// File: tb/tb_ps2_field_entry.sv
// Directed bench for ps2_field_entry: key sequences with hand-computed buffer,
// commit timing and committed values.
module tb_ps2_field_entry;
    logic        CLOCK_50;
    logic        reset;
    logic [7:0]  data;
    logic        data_en;
    logic [29:0] values;
    logic [2:0]  commit;
    logic        editing;
    logic [1:0]  sel;
    logic [11:0] digits_bcd;
    logic [2:0]  led;

    int chk_cnt = 0;
    int err_cnt = 0;

    ps2_field_entry #(
        .NUM_FIELDS(3), .DIGITS(3), .VAL_W(10),
        .MIN_VAL(0), .MAX_VAL(300), .PULSE_DIV(12_500_000)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .data      (data),
        .data_en   (data_en),
        .values    (values),
        .commit    (commit),
        .editing   (editing),
        .sel       (sel),
        .digits_bcd(digits_bcd),
        .led       (led)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] field_of(input int f);
        return 10'(values >> (f * 10));
    endfunction

    // One strobed byte; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        data    = b;
        data_en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        data_en = 1'b0;
        $display("t=%0t key %02h bcd=%03h sel=%0d editing=%0b", $time, b, digits_bcd, sel, editing);
    endtask

    // Called right after ENTER: commit must equal exp only in the 4th cycle (ENTER+4).
    task automatic watch_commit(input string tag, input logic [2:0] exp);
        for (int k = 0; k < 6; k++) begin
            check_value($sformatf("%s_commit_k%0d", tag, k), 32'(commit), (k == 3) ? 32'(exp) : 32'd0);
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        data    = 8'h00;
        data_en = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_value("rst_values",  32'(values),     32'd0);
        check_value("rst_led",     32'(led),        32'd0);
        check_value("rst_editing", 32'(editing),    32'd0);
        check_value("rst_commit",  32'(commit),     32'd0);
        check_value("rst_bcd",     32'(digits_bcd), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        #1;
        check_value("led_before_edge", 32'(led), 32'd0);
        @(posedge CLOCK_50);
        #1;
        check_value("led_after_edge", 32'(led), 32'h7);

        // F2 with break codes interleaved: 1, 2, 0 -> 120
        send(8'h06); send(8'h16); send(8'hF0); send(8'h16);
        send(8'h1E); send(8'hF0); send(8'h1E); send(8'h45);
        check_value("f2_bcd",     32'(digits_bcd), 32'h120);
        check_value("f2_sel",     32'(sel),        32'd1);
        check_value("f2_editing", 32'(editing),    32'd1);
        check_value("f2_led",     32'(led),        32'b101);
        send(8'h5A);
        watch_commit("f2", 3'b010);
        check_value("f2_value",   32'(field_of(1)), 32'd120);
        check_value("f2_idle",    32'(editing),     32'd0);
        check_value("f2_led_idle", 32'(led),        32'h7);

        // F1, 9 x4: fourth digit ignored, 999 clamps to 300
        send(8'h05);
        for (int i = 0; i < 4; i++) send(8'h46);
        check_value("f1_bcd", 32'(digits_bcd), 32'h999);
        send(8'h5A);
        watch_commit("f1", 3'b001);
        check_value("f1_clamp", 32'(field_of(0)), 32'd300);

        // F3, 4, 5, backspace, 7 -> 47
        send(8'h04);
        send(8'h25); check_value("f3_bcd_a", 32'(digits_bcd), 32'h004);
        send(8'h2E); check_value("f3_bcd_b", 32'(digits_bcd), 32'h045);
        send(8'h66); check_value("f3_bcd_c", 32'(digits_bcd), 32'h004);
        send(8'h3D); check_value("f3_bcd_d", 32'(digits_bcd), 32'h047);
        send(8'h5A);
        watch_commit("f3", 3'b100);
        check_value("f3_value", 32'(field_of(2)), 32'd47);

        // ESC aborts; empty ENTER aborts
        send(8'h05); send(8'h2E); send(8'h76);
        check_value("esc_idle", 32'(editing), 32'd0);
        watch_commit("esc", 3'b000);
        check_value("esc_value", 32'(field_of(0)), 32'd300);
        send(8'h05); send(8'h5A);
        watch_commit("empty", 3'b000);
        check_value("empty_value", 32'(field_of(0)), 32'd300);

        // Extended: E0 16 is discarded, E0 5A acts as ENTER
        send(8'h05); send(8'h16); send(8'hE0); send(8'h16); send(8'h1E);
        check_value("ext_bcd", 32'(digits_bcd), 32'h012);
        send(8'hE0); send(8'h5A);
        watch_commit("ext", 3'b001);
        check_value("ext_value", 32'(field_of(0)), 32'd12);
        check_value("keep_f1",   32'(field_of(1)), 32'd120);

        // Reset during CONVERT: no pulse, all values back to 0
        send(8'h06); send(8'h36); send(8'h5A);
        check_value("mid_commit_k0", 32'(commit), 32'd0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        #1;
        check_value("mid_rst_values",  32'(values),  32'd0);
        check_value("mid_rst_commit",  32'(commit),  32'd0);
        check_value("mid_rst_editing", 32'(editing), 32'd0);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLOCK_50);
            #1;
            check_value($sformatf("post_rst_commit_k%0d", k), 32'(commit), 32'd0);
        end
        check_value("post_rst_values", 32'(values), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ps2_field_entry.md
# ps2_field_entry

Parametrised PS/2 numeric-entry controller that replaces the fixed loop/BPM/move mode selection with a generic set of `NUM_FIELDS` editable numeric fields. It sits between `PS2_Controller` (`received_data` / `received_data_en`) and the sequencer core. Each field is selected by a function key, edited as decimal digits with backspace and escape, converted to binary over several cycles, clamped to a range, and committed with a one-cycle pulse.

## Interface
- `NUM_FIELDS`, 3: number of fields, 1..4; field f is selected by key F(f+1).
- `DIGITS`, 3: maximum decimal digits per entry, 1..4.
- `VAL_W`, 10: width of each committed value.
- `MIN_VAL`, 0: lower clamp bound.
- `MAX_VAL`, 300: upper clamp bound, must be < 2^VAL_W.
- `PULSE_DIV`, 12_500_000: blink half-period in clocks.

Ports:
- `CLOCK_50`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-high reset.
- `data`  in  8: PS/2 set-2 scan byte.
- `data_en`  in  1: one-cycle strobe; `data` is valid when high.
- `values`  out  NUM_FIELDS*VAL_W: committed values; field f occupies bits [f*VAL_W +: VAL_W].
- `commit`  out  NUM_FIELDS: one-cycle pulse on the field just committed.
- `editing`  out  1: high in EDIT, CONVERT and COMMIT.
- `sel`  out  2: field currently or last selected.
- `digits_bcd`  out  DIGITS*4: edit buffer, least-significant digit in [3:0], for HEX display.
- `led`  out  NUM_FIELDS: per-field status LEDs.

## Operation
- Key codes: F1=05, F2=06, F3=04, F4=0C. Digits 0–9 = 45,16,1E,26,25,2E,36,3D,3E,46. ENTER=5A, ESC=76, BACKSPACE=66, break prefix=F0, extended prefix=E0.
- Prefix handling is independent of state:
  - F0 sets `brk`. The next byte is discarded and clears `brk`.
  - E0 sets `ext`. The next make byte is treated as ENTER if it is 5A; otherwise it is discarded. `ext` then clears.
  - `brk` takes priority when both flags are set.
- States are IDLE, EDIT, CONVERT and COMMIT.
- IDLE:
  - A valid F-key (field index < NUM_FIELDS) moves to EDIT, loads `sel`, clears the buffer and clears the digit count `cnt`.
  - All other keys are ignored.
- EDIT:
  - Digit with `cnt` < DIGITS: shift the buffer left one digit, insert the new digit at the LSD, increment `cnt`.
  - Digit with `cnt` = DIGITS: ignored.
  - BACKSPACE: shift the buffer right with zero fill at the MSD, decrement `cnt`. Ignored when `cnt` = 0.
  - ESC: go to IDLE; no value changes and no commit.
  - Valid F-key: switch `sel`, clear the buffer and `cnt`, stay in EDIT.
  - ENTER with `cnt` = 0: go to IDLE with no commit.
  - ENTER with `cnt` > 0: go to CONVERT with `acc` = 0 and digit index = MSD.
- CONVERT:
  - Runs for exactly DIGITS cycles.
  - Each cycle computes `acc` = `acc`*10 + buffer digit, from MSD to LSD.
  - `acc` is 4*DIGITS bits wide; no overflow is possible.
  - `data_en` bytes arriving in CONVERT or COMMIT are dropped, including prefixes.
- COMMIT:
  - Lasts one cycle, then goes to IDLE.
  - `values[sel]` = MAX_VAL if `acc` > MAX_VAL; MIN_VAL if `acc` < MIN_VAL; otherwise `acc` truncated to VAL_W.
  - `commit[sel]` = 1 during this cycle.
  - The buffer is retained until the next selection.
- LEDs:
  - A free-running counter toggles `blink` every PULSE_DIV clocks.
  - IDLE: all `led` bits = 1.
  - EDIT, CONVERT, COMMIT: `led[sel]` = `blink`, all other bits = 1.

## Timing
- Reset values: `values` all MIN_VAL, `commit` 0, `editing` 0, `sel` 0, `digits_bcd` 0, `led` 0, `blink` 0, counter 0, state IDLE, `brk`/`ext` 0.
- `led` stays 0 until the first clock edge after reset deasserts.
- All state updates occur on the CLOCK_50 edge where `data_en` = 1; there is no combinational path from `data` to the outputs.
- Edit latency: `digits_bcd` updates 1 cycle after the key strobe.
- Commit latency, with ENTER strobed at cycle t:
  - CONVERT occupies t+1 .. t+DIGITS.
  - COMMIT occurs at t+DIGITS+1; `values` and `commit` change together there.
  - IDLE at t+DIGITS+2.
- Reset asserted mid-CONVERT or mid-COMMIT: immediate return to reset values; no commit pulse is emitted.
- Back-to-back `data_en` on consecutive cycles must each be processed. No byte may be lost in IDLE or EDIT.

## Test plan
- Reset pulse: `values` all 0, `led` = 000, `editing` = 0. After release, `led` = 111 from the next edge.
- F2, 16, F0 16, 1E, F0 1E, 45, ENTER: `values` field 1 = 120, `commit` = 010 for exactly one cycle at ENTER+4. Break codes must not insert digits.
- F1, 46 ×4, ENTER: the fourth digit is ignored, `acc` = 999, and field 0 is clamped to 300.
- F3, 25, 2E, 66, 3D, ENTER: `digits_bcd` passes through 004 → 045 → 004 → 047, and field 2 = 47.
- F1, 2E, ESC: no commit, field 0 unchanged. F1, ENTER with no digits: no commit. E0 5A after digits 16, 1E commits 12.
- F2, 36, ENTER, then assert `reset` at ENTER+2: `commit` is never asserted and all values return to 0.
